// File: rtl/seq_pkg.sv
// Shared definitions for the random-sequence checker: the 8-entry value
// sequence, FSM state encoding and sequence lookup helpers.
package seq_pkg;

   localparam int unsigned SEQ_LEN = 8;
   localparam int unsigned VAL_W   = 4;
   localparam int unsigned IDX_W   = 3;

   // Sequence values indexed by position
   localparam logic [VAL_W-1:0] SEQ_VALUES [SEQ_LEN] = '{
      4'd0, 4'd4, 4'd7, 4'd8, 4'd10, 4'd13, 4'd9, 4'd15
   };

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // True when v appears somewhere in the sequence
   function automatic logic is_legal(input logic [VAL_W-1:0] v);
      case (v)
         4'd0, 4'd4, 4'd7, 4'd8, 4'd10, 4'd13, 4'd9, 4'd15: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

   // Position of v in the sequence; illegal values map to 0
   function automatic logic [IDX_W-1:0] pos(input logic [VAL_W-1:0] v);
      case (v)
         4'd4:    return 3'd1;
         4'd7:    return 3'd2;
         4'd8:    return 3'd3;
         4'd10:   return 3'd4;
         4'd13:   return 3'd5;
         4'd9:    return 3'd6;
         4'd15:   return 3'd7;
         default: return 3'd0;
      endcase
   endfunction

   // Value that follows v, wrapping 15 back to 0
   function automatic logic [VAL_W-1:0] succ(input logic [VAL_W-1:0] v);
      return SEQ_VALUES[IDX_W'(pos(v) + 3'd1)];
   endfunction

endpackage

// File: rtl/random_sequence_checker_if.sv
// Sample/status bundle between a sequence source and the checker.
// err_count exists only when SEQ_ERR_COUNT_EN is defined.
interface random_sequence_checker_if
`ifdef SEQ_ERR_COUNT_EN
   #(parameter int unsigned ERR_W = 8)
`endif
   ;
   import seq_pkg::*;

   logic             valid;
   logic [VAL_W-1:0] q;
   logic             locked;
   logic             error;
   logic [IDX_W-1:0] index;
   logic [VAL_W-1:0] expected;
`ifdef SEQ_ERR_COUNT_EN
   logic [ERR_W-1:0] err_count;
`endif

   modport master (
      output valid, q,
      input  locked, error, index, expected
`ifdef SEQ_ERR_COUNT_EN
      , input err_count
`endif
   );

   modport slave (
      input  valid, q,
      output locked, error, index, expected
`ifdef SEQ_ERR_COUNT_EN
      , output err_count
`endif
   );

endinterface

// File: rtl/seq_decode.sv
// Combinational decode of a sample into legality flag and sequence position.
module seq_decode
   import seq_pkg::*;
(
   input  logic [VAL_W-1:0] q,
   output logic             legal,
   output logic [IDX_W-1:0] position
);

   // Table lookup via the shared helpers
   always_comb begin
      legal    = is_legal(q);
      position = pos(q);
   end

endmodule

// File: rtl/random_sequence_checker.sv
// Receive-side checker for the 0,4,7,8,10,13,9,15 sequence: hunts for a seed,
// verifies LOCK_COUNT successors, then tracks and flags mismatches, dropping
// lock after MISS_LIMIT consecutive misses.
// Optional saturating error counter enabled by SEQ_ERR_COUNT_EN.
module random_sequence_checker
   import seq_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 2,
   parameter int unsigned MISS_LIMIT = 2
`ifdef SEQ_ERR_COUNT_EN
   , parameter int unsigned ERR_W = 8
`endif
)(
   input  logic clk,
   input  logic clear,
   random_sequence_checker_if.slave bus
);

   localparam int unsigned CNT_W = 3;

   state_t           state;
   logic [CNT_W-1:0] run;
   logic [CNT_W-1:0] miss;

   logic             legal;
   logic [IDX_W-1:0] q_pos;
   logic [IDX_W-1:0] seed_index;
   logic [VAL_W-1:0] seed_expected;
   logic [IDX_W-1:0] adv_index;
   logic [VAL_W-1:0] adv_expected;
   logic [CNT_W-1:0] run_inc;
   logic [CNT_W-1:0] miss_inc;
   logic             match;
   logic             miss_hit;

   seq_decode u_decode (
      .q        (bus.q),
      .legal    (legal),
      .position (q_pos)
   );

   // Seed/advance targets and the locked-mismatch condition
   always_comb begin
      seed_index    = q_pos;
      seed_expected = SEQ_VALUES[IDX_W'(q_pos + 3'd1)];
      adv_index     = IDX_W'(bus.index + 3'd1);
      adv_expected  = SEQ_VALUES[IDX_W'(bus.index + 3'd2)];
      run_inc       = CNT_W'(run + 3'd1);
      miss_inc      = CNT_W'(miss + 3'd1);
      match         = (bus.q == bus.expected);
      miss_hit      = bus.valid && (state == LOCKED) && !match;
   end

   // Lock FSM with registered status outputs
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state        <= HUNT;
         run          <= '0;
         miss         <= '0;
         bus.locked   <= 1'b0;
         bus.error    <= 1'b0;
         bus.index    <= '0;
         bus.expected <= '0;
      end else begin
         bus.error <= 1'b0;
         if (bus.valid) begin
            case (state)
               HUNT: begin
                  if (legal) begin
                     bus.index    <= seed_index;
                     bus.expected <= seed_expected;
                     run          <= '0;
                     state        <= VERIFY;
                  end
               end
               VERIFY: begin
                  if (match) begin
                     run          <= run_inc;
                     bus.index    <= adv_index;
                     bus.expected <= adv_expected;
                     if (run_inc == CNT_W'(LOCK_COUNT)) begin
                        state      <= LOCKED;
                        bus.locked <= 1'b1;
                        miss       <= '0;
                     end
                  end else if (legal) begin
                     bus.index    <= seed_index;
                     bus.expected <= seed_expected;
                     run          <= '0;
                  end else begin
                     state <= HUNT;
                  end
               end
               LOCKED: begin
                  // Flywheel: position advances whether or not the sample matched
                  bus.index    <= adv_index;
                  bus.expected <= adv_expected;
                  if (match) begin
                     miss <= '0;
                  end else begin
                     bus.error <= 1'b1;
                     miss      <= miss_inc;
                     if (miss_inc == CNT_W'(MISS_LIMIT)) begin
                        state      <= HUNT;
                        bus.locked <= 1'b0;
                     end
                  end
               end
               default: begin
                  state      <= HUNT;
                  bus.locked <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SEQ_ERR_COUNT_EN
   // Saturating count of error pulses; survives loss of lock
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         bus.err_count <= '0;
      end else if (miss_hit && (bus.err_count != {ERR_W{1'b1}})) begin
         bus.err_count <= ERR_W'(bus.err_count + 1'b1);
      end
   end
`endif

endmodule
